// File: rtl/cpu_pkg.sv
// Shared opcode encodings and sequencer state type for the 9-bit,
// 3-bit-opcode CPU.
package cpu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_LD  = 3'b011;
  localparam logic [2:0] OP_ST  = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_BNE = 3'b110;
  localparam logic [2:0] OP_SET = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEMWAIT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: owns pc/ir, steps FETCH/DECODE/EXEC(/MEMWAIT),
// gates register/memory writes with commit pulses and resolves the next pc.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | imem_addr = pc presented to instruction memory
// DECODE  | instruction data captured into ir
// EXEC    | opcode valid; commit pulse; resolve next pc (except load)
// MEMWAIT | load data valid; register commit; resolve next pc
// DONE    | run complete; waits for start to drop
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int OP_W    = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [PC_W-1:0]    prog_len,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic [OP_W-1:0]    opcode,
  output logic               reg_commit,
  output logic               mem_commit,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   retired
);

  seq_state_t      state;
  logic [OP_W-1:0] fetched_op;
  logic [PC_W-1:0] npc;

  assign imem_addr  = pc;
  assign opcode     = ir[INSTR_W-1 -: OP_W];
  assign fetched_op = imem_rdata[INSTR_W-1 -: OP_W];
  assign npc        = (opcode == OP_W'(OP_BNE) && branch_taken) ? branch_target
                                                               : pc + PC_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc         <= '0;
      ir         <= '0;
      retired    <= '0;
      reg_commit <= 1'b0;
      mem_commit <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      reg_commit <= 1'b0;
      mem_commit <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (prog_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              pc      <= '0;
              retired <= '0;
              state   <= FETCH;
              busy    <= 1'b1;
            end
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          // Commits are registered here so they are high for exactly the EXEC cycle.
          ir         <= imem_rdata;
          state      <= EXEC;
          mem_commit <= (fetched_op == OP_W'(OP_ST));
          reg_commit <= !(fetched_op == OP_W'(OP_LD) || fetched_op == OP_W'(OP_ST) ||
                          fetched_op == OP_W'(OP_BNE));
        end
        EXEC, MEMWAIT: begin
          if (state == EXEC && opcode == OP_W'(OP_LD)) begin
            state      <= MEMWAIT;
            reg_commit <= 1'b1;
          end else begin
            pc      <= npc;
            retired <= (retired == '1) ? retired : retired + CNT_W'(1);
            if (npc >= prog_len) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
